// File: rtl/debounce_pkg.sv
// Shared encodings and default timing constants for the button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HELD   = 2'd2,
    ST_CHK_LO = 2'd3
  } state_e;

  localparam int unsigned DEF_CNT_WIDTH     = 26;
  localparam int unsigned DEF_STABLE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY  = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10000000;

  // True when value is a usable terminal count for a width-bit counter.
  function automatic bit fits_counter(input int unsigned value, input int unsigned width);
    return (value >= 1) && ((64'(value) >> width) == 64'd0);
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Control/status link between the debouncer FSM (master) and its timing counter (slave).
interface debounce_timer_if
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) ();

  logic                 clr;
  logic                 en;
  logic [CNT_WIDTH-1:0] term;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 hit_c;

  modport master (output clr, output en, output term, input cnt, input hit_c);
  modport slave  (input clr, input en, input term, output cnt, output hit_c);

endinterface

// File: rtl/button_debouncer_timer.sv
// Clearable, saturating up-counter with a terminal-count compare output.
module debounce_timer
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic              Clk,
  input logic              Rst,
  debounce_timer_if.slave  tif
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] r_cnt;

  // Clear wins over enable; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge Clk) begin
    if (Rst || tif.clr) begin
      r_cnt <= '0;
    end else if (tif.en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign tif.cnt   = r_cnt;
  assign tif.hit_c = (r_cnt == tif.term);

endmodule

// File: rtl/button_debouncer.sv
// Button debouncer: four-state level qualifier with press/release pulses.
// Optional auto-repeat of Pressed while held is enabled by DEBOUNCER_AUTO_REPEAT_EN.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic Clk,
  input  logic Rst,
  input  logic InSignal,
  output logic DebouncedOut,
  output logic Pressed,
  output logic Released
);

  localparam bit P_OK = fits_counter(STABLE_CYCLES, CNT_WIDTH) &&
                        fits_counter(REPEAT_DELAY, CNT_WIDTH) &&
                        fits_counter(REPEAT_PERIOD, CNT_WIDTH);

  localparam logic [CNT_WIDTH-1:0] STABLE_TERM = CNT_WIDTH'(STABLE_CYCLES - 1);
`ifdef DEBOUNCER_AUTO_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] DELAY_TERM  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_TERM = CNT_WIDTH'(REPEAT_PERIOD - 1);
`endif

  state_e r_state;
  logic   r_rep;
  logic   r_debounced;
  logic   r_pressed;
  logic   r_released;

  logic                 w_rep_hit;
  logic [CNT_WIDTH-1:0] w_term;

  debounce_timer_if #(.CNT_WIDTH(CNT_WIDTH)) w_tmr ();

  debounce_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .Clk (Clk),
    .Rst (Rst),
    .tif (w_tmr)
  );

  // Terminal count: qualification window, or first/next repeat interval while held.
`ifdef DEBOUNCER_AUTO_REPEAT_EN
  assign w_term = (r_state == ST_HELD) ? (r_rep ? PERIOD_TERM : DELAY_TERM) : STABLE_TERM;
`else
  assign w_term = STABLE_TERM;
`endif
  assign w_tmr.term = w_term;

  // Counter control: count while the input agrees with the pending level, clear on every state change.
  always_comb begin
    w_tmr.en  = 1'b0;
    w_tmr.clr = 1'b0;
    w_rep_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tmr.clr = 1'b1;
      end
      ST_CHK_HI: begin
        w_tmr.en  = InSignal;
        w_tmr.clr = !InSignal || w_tmr.hit_c;
      end
      ST_HELD: begin
`ifdef DEBOUNCER_AUTO_REPEAT_EN
        w_tmr.en  = InSignal;
        w_rep_hit = InSignal && w_tmr.hit_c;
`endif
        w_tmr.clr = !InSignal || w_rep_hit;
      end
      ST_CHK_LO: begin
        w_tmr.en  = !InSignal;
        w_tmr.clr = InSignal || w_tmr.hit_c;
      end
      default: begin
        w_tmr.clr = 1'b1;
      end
    endcase
  end

  // State register with registered level and pulse outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= ST_IDLE;
      r_rep       <= 1'b0;
      r_debounced <= 1'b0;
      r_pressed   <= 1'b0;
      r_released  <= 1'b0;
    end else begin
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (InSignal) begin
            r_state <= ST_CHK_HI;
          end
        end
        ST_CHK_HI: begin
          if (!InSignal) begin
            r_state <= ST_IDLE;
          end else if (w_tmr.hit_c) begin
            r_state     <= ST_HELD;
            r_rep       <= 1'b0;
            r_debounced <= 1'b1;
            r_pressed   <= 1'b1;
          end
        end
        ST_HELD: begin
          if (!InSignal) begin
            r_state <= ST_CHK_LO;
          end else if (w_rep_hit) begin
            r_rep     <= 1'b1;
            r_pressed <= 1'b1;
          end
        end
        ST_CHK_LO: begin
          if (InSignal) begin
            // Bounce during release: stay pressed and restart repeat timing from scratch.
            r_state <= ST_HELD;
            r_rep   <= 1'b0;
          end else if (w_tmr.hit_c) begin
            r_state     <= ST_IDLE;
            r_debounced <= 1'b0;
            r_released  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign DebouncedOut = r_debounced;
  assign Pressed      = r_pressed;
  assign Released     = r_released;

  // Simulation-only sanity checks on configuration and internal invariants.
  always_ff @(posedge Clk) begin
    a_params: assert (P_OK)
      else $error("button_debouncer: STABLE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD must be in [1, 2^CNT_WIDTH)");
    a_excl: assert (!(r_pressed && r_released))
      else $error("button_debouncer: Pressed and Released high together");
    a_cnt: assert (!((r_state == ST_CHK_HI) || (r_state == ST_CHK_LO)) ||
                   (64'(w_tmr.cnt) < 64'(STABLE_CYCLES)))
      else $error("button_debouncer: qualification counter overran its window");
`ifndef DEBOUNCER_AUTO_REPEAT_EN
    a_no_rep: assert (!r_rep)
      else $error("button_debouncer: repeat flag set with auto-repeat disabled");
`endif
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (S=4, RD=10, RP=3, W=8) plus a standalone timer check.
module tb_button_debouncer;

  localparam int unsigned W  = 8;
  localparam int unsigned S  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;
`ifdef DEBOUNCER_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic Clk;
  logic Rst;
  logic InSignal;
  logic DebouncedOut;
  logic Pressed;
  logic Released;
  logic t_rst;

  int unsigned n_vec;
  int unsigned n_err;

  button_debouncer #(
    .CNT_WIDTH     (W),
    .STABLE_CYCLES (S),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .InSignal     (InSignal),
    .DebouncedOut (DebouncedOut),
    .Pressed      (Pressed),
    .Released     (Released)
  );

  debounce_timer_if #(.CNT_WIDTH(3)) t_if ();

  debounce_timer #(.CNT_WIDTH(3)) u_tmr (
    .Clk (Clk),
    .Rst (t_rst),
    .tif (t_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one sample at the next rising edge, then settle just after it.
  task automatic step(input logic rst, input logic din);
    Rst      = rst;
    InSignal = din;
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic d, input logic p, input logic r);
    check({tag, ".dbo"}, 32'(DebouncedOut), 32'(d));
    check({tag, ".prs"}, 32'(Pressed), 32'(p));
    check({tag, ".rel"}, 32'(Released), 32'(r));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    Rst       = 1'b1;
    InSignal  = 1'b0;
    t_rst     = 1'b1;
    t_if.clr  = 1'b0;
    t_if.en   = 1'b0;
    t_if.term = 3'd5;

    // Standalone timer: count, terminal hit, saturation, clear, hold.
    @(posedge Clk); #1;
    t_rst = 1'b0;
    check("tmr.reset", 32'(t_if.cnt), 32'd0);
    t_if.en = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    check("tmr.cnt5", 32'(t_if.cnt), 32'd5);
    check("tmr.hit5", 32'(t_if.hit_c), 32'd1);
    repeat (4) @(posedge Clk);
    #1;
    check("tmr.sat", 32'(t_if.cnt), 32'd7);
    check("tmr.nohit", 32'(t_if.hit_c), 32'd0);
    t_if.clr = 1'b1;
    @(posedge Clk); #1;
    check("tmr.clr", 32'(t_if.cnt), 32'd0);
    t_if.clr = 1'b0;
    t_if.en  = 1'b0;
    @(posedge Clk); #1;
    check("tmr.hold", 32'(t_if.cnt), 32'd0);

    // Reset state.
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    expect_out("reset", 1'b0, 1'b0, 1'b0);

    // Clean press held through edge 20: press at 4, repeats at 14/17/20 when enabled.
    for (int e = 0; e <= 20; e++) begin
      step(1'b0, 1'b1);
      expect_out($sformatf("press.e%0d", e), e >= 4,
                 (e == 4) || (AR && ((e == 14) || (e == 17) || (e == 20))), 1'b0);
    end

    // Release: five low samples, Released on the fifth.
    for (int e = 0; e <= 5; e++) begin
      step(1'b0, 1'b0);
      expect_out($sformatf("release.e%0d", e), e < 4, 1'b0, e == 4);
    end

    // Bounce while idle is rejected.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i < 4) ? logic'(i % 2 == 0) : 1'b0);
      expect_out($sformatf("bounce_lo.i%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // Fresh press.
    for (int e = 0; e <= 4; e++) begin
      step(1'b0, 1'b1);
      expect_out($sformatf("press2.e%0d", e), e == 4, e == 4, 1'b0);
    end

    // Bounce while held: no release, repeat restarts from the last return to high.
    for (int i = 0; i < 14; i++) begin
      step(1'b0, (i < 4) ? logic'(i % 2 == 1) : 1'b1);
      expect_out($sformatf("bounce_hi.i%0d", i), 1'b1, AR && (i == 13), 1'b0);
    end

    for (int e = 0; e <= 4; e++) begin
      step(1'b0, 1'b0);
      expect_out($sformatf("release2.e%0d", e), e < 4, 1'b0, e == 4);
    end

    // Reset at edge 2 of qualification.
    step(1'b0, 1'b1);
    expect_out("rst_chk.e0", 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    expect_out("rst_chk.e1", 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    expect_out("rst_chk.e2", 1'b0, 1'b0, 1'b0);

    // Requalify from scratch with the input already high, then reset at edge 15 in HELD.
    for (int e = 0; e <= 14; e++) begin
      step(1'b0, 1'b1);
      expect_out($sformatf("requal.e%0d", e), e >= 4, (e == 4) || (AR && (e == 14)), 1'b0);
    end
    step(1'b1, 1'b1);
    expect_out("rst_held.e15", 1'b0, 1'b0, 1'b0);

    for (int e = 0; e <= 5; e++) begin
      step(1'b0, 1'b1);
      expect_out($sformatf("requal2.e%0d", e), e >= 4, e == 4, 1'b0);
    end

    step(1'b1, 1'b0);
    expect_out("final_rst", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 26: width of the shared timing counter.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1000000: the input must stay at the new level for this many cycles before the debounced level changes.
REQ-003 SHALL have parameter REPEAT_DELAY, default 50000000: cycles from the initial press pulse to the first auto-repeat pulse.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses.
REQ-005 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port InSignal, input, 1 bit: button level, already synchronized to Clk by the upstream synchronizer stage.
REQ-008 SHALL have port DebouncedOut, output, 1 bit: filtered, registered button level.
REQ-009 SHALL have port Pressed, output, 1 bit: one-cycle pulse on each debounced press and on each auto-repeat.
REQ-010 SHALL have port Released, output, 1 bit: one-cycle pulse on each debounced release.

Function
REQ-011 SHALL implement four states: IDLE (stable low), CHK_HI (qualifying high), HELD (stable high), CHK_LO (qualifying low).
REQ-012 In IDLE with InSignal=1: go to CHK_HI and clear the counter; with InSignal=0: stay in IDLE.
REQ-013 In CHK_HI with InSignal=0: return to IDLE and clear the counter, with no output change (glitch rejected).
REQ-014 In CHK_HI: the counter increments on each edge where InSignal=1; at the edge where counter==STABLE_CYCLES-1 and InSignal=1, go to HELD.
- That edge sets DebouncedOut=1 and Pressed=1 for exactly one cycle.
- Total latency is STABLE_CYCLES+1 consecutive high samples.
REQ-015 In HELD with InSignal=0: go to CHK_LO and clear the counter.
REQ-016 CHK_LO mirrors CHK_HI with the polarity inverted.
- InSignal=1 returns to HELD with no pulse, and repeat timing restarts from zero.
- Qualification completes by going to IDLE, setting DebouncedOut=0 and pulsing Released for one cycle.
REQ-017 All outputs SHALL be registered; Pressed and Released SHALL never be high in the same cycle.
REQ-018 The counter SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
- Each of STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD SHALL be >=1 and <2^CNT_WIDTH.
- A simulation-time check SHALL flag any violation.

Reset
REQ-019 Rst=1 at an edge SHALL force IDLE, counter=0, repeat flag=0, DebouncedOut=0, Pressed=0 and Released=0.
- Rst has priority over every transition, including one mid-qualification or mid-repeat.
REQ-020 If InSignal=1 when Rst is released, the block SHALL qualify it normally from IDLE and produce a Pressed pulse.

Configuration
REQ-021 Macro DEBOUNCER_AUTO_REPEAT_EN defined: in HELD, Pressed SHALL pulse at the edge REPEAT_DELAY edges after the initial press pulse, then every REPEAT_PERIOD edges while the block remains in HELD.
REQ-022 Macro DEBOUNCER_AUTO_REPEAT_EN undefined: the counter SHALL hold in HELD, no repeat pulses SHALL occur, and REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored.

Structure
REQ-023 Package debounce_pkg SHALL hold the state encoding (2-bit: IDLE=0, CHK_HI=1, HELD=2, CHK_LO=3) and the default parameter constants.
REQ-024 The block SHALL contain exactly one sub-module, debounce_timer: a CNT_WIDTH-bit clearable, saturating up-counter with an enable input and a terminal-compare input.
REQ-025 The block SHALL NOT instantiate a synchronizer; the synchronizer stage is external and upstream.

Verification (STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CNT_WIDTH=8)
REQ-026 Clean press: InSignal=1 sampled at edges 0-4 -> DebouncedOut=1 and Pressed=1 after edge 4; Pressed=0 after edge 5.
REQ-027 Bounce: InSignal toggled 1,0,1,0 on edges 0-3, then held at 0 -> no Pressed, DebouncedOut stays 0; same pattern during HELD -> no Released.
REQ-028 Release: after a qualified press, InSignal=0 sampled at 5 consecutive edges -> DebouncedOut=0 and Released pulses exactly once at the 5th edge.
REQ-029 Auto-repeat with macro defined, button held: initial Pressed at edge 4, repeats at edges 14, 17, 20. With macro undefined: only the edge-4 pulse.
REQ-030 Reset mid-operation: Rst=1 at edge 2 of CHK_HI, then at edge 15 while in HELD -> outputs 0 at the next cycle, state IDLE, no pulses emitted; requalification takes 5 fresh samples.
